exp_adder_bias_pipe: RTL

//  Pipelined, parametrised exponent path for the FP multiplier: adds two biased

---
 rtl/exp_adder_bias_pipe_if.sv | 26 ++
 rtl/exp_adder_bias_pipe.sv | 87 ++++++++
 2 files changed

// File: rtl/exp_adder_bias_pipe_if.sv
// Operand/result handshake bundle for the exponent adder pipe.
// slave = the pipe itself, master = the producer/consumer side around it.
interface exp_adder_bias_pipe_if #(
   parameter int EXP_W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [EXP_W-1:0] exp_a;
   logic [EXP_W-1:0] exp_b;
   logic             out_valid;
   logic             out_ready;
   logic [EXP_W-1:0] exp_out;
   logic             ovf;
   logic             unf;
   logic             zero_out;

   modport slave (
      input  in_valid, exp_a, exp_b, out_ready,
      output in_ready, out_valid, exp_out, ovf, unf, zero_out
   );

   modport master (
      output in_valid, exp_a, exp_b, out_ready,
      input  in_ready, out_valid, exp_out, ovf, unf, zero_out
   );
endinterface

// File: rtl/exp_adder_bias_pipe.sv
// Biased exponent adder for the FP multiplier: a+b-BIAS with ovf/unf/zero classification.
// Latency 2, one result per cycle; in_ready is combinational from out_ready (no skid buffer).
// Build option EXP_SAT_EN: saturate exp_out on ovf/unf instead of wrapping.
module exp_adder_bias_pipe #(
   parameter int EXP_W = 8,
   parameter int BIAS  = 127
) (
   input  logic                 clk,
   input  logic                 rst,
   exp_adder_bias_pipe_if.slave bus,
   input  logic                 clr_sticky,
   output logic                 sticky_ovf,
   output logic                 sticky_unf
);
   localparam logic signed [EXP_W+1:0] BIAS_S = (EXP_W+2)'(BIAS);
   localparam logic signed [EXP_W+1:0] MAX_S  = (EXP_W+2)'((1 << EXP_W) - 1);
   localparam logic signed [EXP_W+1:0] ZERO_S = '0;

   logic             s1_valid;
   logic [EXP_W:0]   s1_sum;
   logic             s1_z;

   logic             s2_adv;
   logic             s1_adv;
   logic             res_xfer;

   logic signed [EXP_W+1:0] d;
   logic                    s2_ovf;
   logic                    s2_unf;
   logic [EXP_W-1:0]        s2_exp;

   assign s2_adv       = !bus.out_valid || bus.out_ready;
   assign s1_adv       = !s1_valid || s2_adv;
   assign bus.in_ready = s1_adv;
   assign res_xfer     = bus.out_valid && bus.out_ready;

   // Two extra bits: one for the carry of the add, one for the sign after BIAS removal.
   always_comb begin
      d      = $signed({1'b0, s1_sum}) - BIAS_S;
      s2_ovf = !s1_z && (d >= MAX_S);
      s2_unf = !s1_z && (d <= ZERO_S);
      s2_exp = d[EXP_W-1:0];
`ifdef EXP_SAT_EN
      if (s2_ovf)
         s2_exp = '1;
      else if (s2_unf)
         s2_exp = '0;
`endif
      if (s1_z)
         s2_exp = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid      <= 1'b0;
         s1_sum        <= '0;
         s1_z          <= 1'b0;
         bus.out_valid <= 1'b0;
         bus.exp_out   <= '0;
         bus.ovf       <= 1'b0;
         bus.unf       <= 1'b0;
         bus.zero_out  <= 1'b0;
         sticky_ovf    <= 1'b0;
         sticky_unf    <= 1'b0;
      end else begin
         if (s1_adv) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
               s1_sum <= {1'b0, bus.exp_a} + {1'b0, bus.exp_b};
               s1_z   <= (bus.exp_a == '0) || (bus.exp_b == '0);
            end
         end
         if (s2_adv) begin
            bus.out_valid <= s1_valid;
            if (s1_valid) begin
               bus.exp_out  <= s2_exp;
               bus.ovf      <= s2_ovf;
               bus.unf      <= s2_unf;
               bus.zero_out <= s1_z;
            end
         end
         // A flag raised by the transferring result survives a simultaneous clear.
         sticky_ovf <= (sticky_ovf & ~clr_sticky) | (res_xfer & bus.ovf);
         sticky_unf <= (sticky_unf & ~clr_sticky) | (res_xfer & bus.unf);
      end
   end
endmodule
